tof_fb_clear_arbiter: RTL and testbench
=======================================

TOF_FB_CLEAR_ARBITER -- requirements
Module: tof_fb_clear_arbiter

Interface
REQ-001 The module SHALL have exactly one clock domain; reset is synchronous and active-high.
REQ-002 Parameter CLEAR_ON_RESET, default 1: when 1, a full clear sweep starts automatically after reset.
REQ-003 clk_sys  input  1  system clock, 100 MHz.
REQ-004 rst_sys  input  1  synchronous active-high reset.
REQ-005 clear_req  input  1  single-cycle request to clear the framebuffer.
REQ-006 pt_wr_en, pt_wr_x, pt_wr_y, pt_wr_data  input  1/8/8/1  plot-point write strobe, column, row and pixel value from the point writer.
REQ-007 clear_busy  output  1  high while a clear sweep is in progress; the point writer uses it to gate writes.
REQ-008 fb_we, fb_addr, fb_din  output  1/16/1  registered framebuffer write port.
REQ-009 frame_done  output  1  single-cycle pulse when a clear sweep completes.
REQ-010 drop_cnt  output  16  saturating count of point writes that were dropped.
REQ-011 pts_written  output  16  saturating count of point writes issued since the last clear started.

Function
REQ-012 The state machine SHALL have states IDLE and CLEAR only; frame_done is a registered pulse.
REQ-013 fb_addr SHALL be {row, col}, i.e. {y[7:0], x[7:0]}, for both point and clear writes.
REQ-014 IDLE, pt_wr_en=1, clear_req=0 (cycle n): in cycle n+1, fb_we=1, fb_addr={pt_wr_y,pt_wr_x}, fb_din=pt_wr_data; pts_written increments (saturates at 0xFFFF). Latency is 1 cycle.
REQ-015 IDLE, no pt_wr_en: fb_we=0 in the next cycle; fb_addr and fb_din hold their last values.
REQ-016 IDLE, clear_req=1 (cycle n): in cycle n+1, state=CLEAR, clear_busy=1, fb_we=1, fb_addr=0, fb_din=0; pts_written is set to 0.
REQ-017 clear_req and pt_wr_en together in IDLE: the clear wins; the point write is dropped and drop_cnt increments.
REQ-018 CLEAR: one write per cycle with fb_din=0, and fb_addr increments by 1 each cycle; address 0xFFFF is written in cycle n+65536.
REQ-019 Cycle after the 0xFFFF write (n+65537): state=IDLE, clear_busy=0, fb_we=0, frame_done=1 for exactly one cycle.
REQ-020 pt_wr_en during CLEAR: the write is dropped, never issued; drop_cnt increments.
REQ-021 clear_req during CLEAR: ignored, not queued; the sweep is not restarted.
REQ-022 A pt_wr_en in the cycle frame_done is high SHALL be handled as in IDLE (REQ-014).
REQ-023 drop_cnt SHALL saturate at 0xFFFF and is cleared only by reset.
REQ-024 The sweep address counter is 17 bits internally, so the terminal-count compare needs no wrap-around ambiguity.

Reset
REQ-025 While rst_sys=1, every output SHALL hold its reset value:
- fb_we=0, fb_addr=0, fb_din=0
- frame_done=0, drop_cnt=0, pts_written=0
- clear_busy=CLEAR_ON_RESET; state=CLEAR if CLEAR_ON_RESET=1, else IDLE; sweep counter=0
REQ-026 With CLEAR_ON_RESET=1, the first edge with rst_sys=0 registers the clear write to address 0; the sweep then proceeds per REQ-018/019.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep on the same edge and apply REQ-025.

Structure
REQ-028 A shared package SHALL hold:
- FB_COORD_W=8, FB_ADDR_W=16, FB_DEPTH=65536
- the state encoding
REQ-029 There SHALL be one sub-module, tof_sat_counter (parameterised width, inc, clr), instantiated for drop_cnt and pts_written.
REQ-030 The block has no combinational path from any input to any output; all outputs are registered.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- CLEAR_ON_RESET=1, release reset, no stimulus -> 65536 consecutive fb_we cycles, addresses 0..0xFFFF, fb_din=0, then one frame_done pulse with clear_busy falling in the same cycle.
- IDLE, pt_wr_en with x=0x12, y=0x34, data=1 -> next cycle fb_we=1, fb_addr=0x3412, fb_din=1, pts_written=1.
- clear_req and pt_wr_en in the same cycle -> drop_cnt=1, first clear write fb_addr=0, pts_written=0.
- Point writes at sweep cycles 1, 1000 and 65535 -> no fb_we with fb_din=1 during the sweep, drop_cnt=3.
- Second clear_req at sweep cycle 500 -> sweep still ends exactly at cycle 65537 after the original request; exactly one frame_done pulse.
- rst_sys pulsed at sweep address 0x8000 -> outputs at reset values, and the sweep restarts from address 0 (CLEAR_ON_RESET=1).

Source files
------------

// File: rtl/tof_fb_clear_arbiter_pkg.sv
// rtl/tof_fb_clear_arbiter_pkg.sv - shared framebuffer geometry and arbiter state encoding
package tof_fb_clear_arbiter_pkg;

    localparam int FB_COORD_W  = 8;
    localparam int FB_ADDR_W   = 16;
    localparam int FB_DEPTH    = 65536;

    // One extra bit so the sweep counter can reach FB_DEPTH itself as its terminal value
    localparam int SWEEP_CNT_W = FB_ADDR_W + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/tof_sat_counter.sv
// rtl/tof_sat_counter.sv - saturating up-counter with synchronous clear
module tof_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_sys,
    input  logic             rst_sys,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    // Count up on inc, stick at all-ones, clear has priority over inc
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/tof_fb_clear_arbiter.sv
// rtl/tof_fb_clear_arbiter.sv - arbitrates framebuffer writes between point writer and clear sweep
module tof_fb_clear_arbiter
    import tof_fb_clear_arbiter_pkg::*;
#(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys,
    input  logic                  clear_req,
    input  logic                  pt_wr_en,
    input  logic [FB_COORD_W-1:0] pt_wr_x,
    input  logic [FB_COORD_W-1:0] pt_wr_y,
    input  logic                  pt_wr_data,
    output logic                  clear_busy,
    output logic                  fb_we,
    output logic [FB_ADDR_W-1:0]  fb_addr,
    output logic                  fb_din,
    output logic                  frame_done,
    output logic [15:0]           drop_cnt,
    output logic [15:0]           pts_written
);

    localparam arb_state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    arb_state_t             state_q;
    arb_state_t             state_d;
    logic [SWEEP_CNT_W-1:0] sweep_q;
    logic [SWEEP_CNT_W-1:0] sweep_d;
    logic                   fb_we_d;
    logic [FB_ADDR_W-1:0]   fb_addr_d;
    logic                   fb_din_d;
    logic                   frame_done_d;
    logic                   drop_inc;
    logic                   pt_inc;
    logic                   pt_clr;

    // State is a single flop, so busy is a registered output
    assign clear_busy = (state_q == ST_CLEAR);

    // Next-state and next-output decode; sweep_q holds the next address to clear
    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr;
        fb_din_d     = fb_din;
        frame_done_d = 1'b0;
        drop_inc     = 1'b0;
        pt_inc       = 1'b0;
        pt_clr       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    fb_we_d   = 1'b1;
                    fb_addr_d = '0;
                    fb_din_d  = 1'b0;
                    sweep_d   = SWEEP_CNT_W'(1);
                    pt_clr    = 1'b1;
                    drop_inc  = pt_wr_en;
                end else if (pt_wr_en) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = {pt_wr_y, pt_wr_x};
                    fb_din_d  = pt_wr_data;
                    pt_inc    = 1'b1;
                end
            end
            ST_CLEAR: begin
                drop_inc = pt_wr_en;
                if (sweep_q == SWEEP_CNT_W'(FB_DEPTH)) begin
                    state_d      = ST_IDLE;
                    sweep_d      = '0;
                    frame_done_d = 1'b1;
                end else begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = sweep_q[FB_ADDR_W-1:0];
                    fb_din_d  = 1'b0;
                    sweep_d   = sweep_q + SWEEP_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, sweep counter and framebuffer port registers
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q    <= RESET_STATE;
            sweep_q    <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_din     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            fb_we      <= fb_we_d;
            fb_addr    <= fb_addr_d;
            fb_din     <= fb_din_d;
            frame_done <= frame_done_d;
        end
    end

    tof_sat_counter #(
        .WIDTH (16)
    ) u_drop_cnt (
        .clk_sys (clk_sys),
        .rst_sys (rst_sys),
        .inc     (drop_inc),
        .clr     (1'b0),
        .cnt     (drop_cnt)
    );

    tof_sat_counter #(
        .WIDTH (16)
    ) u_pts_written (
        .clk_sys (clk_sys),
        .rst_sys (rst_sys),
        .inc     (pt_inc),
        .clr     (pt_clr),
        .cnt     (pts_written)
    );

endmodule

// File: tb/tb_tof_fb_clear_arbiter.sv
// tb/tb_tof_fb_clear_arbiter.sv - directed scoreboard bench for the framebuffer clear arbiter
module tb_tof_fb_clear_arbiter;
    import tof_fb_clear_arbiter_pkg::*;

    logic        clk_sys;
    logic        rst_sys;
    logic        clear_req;
    logic        pt_wr_en;
    logic [7:0]  pt_wr_x;
    logic [7:0]  pt_wr_y;
    logic        pt_wr_data;
    logic        clear_busy;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic        fb_din;
    logic        frame_done;
    logic [15:0] drop_cnt;
    logic [15:0] pts_written;

    logic [16:0] sb[$];
    logic [16:0] exp_wr;
    int          tests;
    int          fails;
    int          sw;
    int          done_cnt;
    int          done0;

    tof_fb_clear_arbiter #(
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_sys     (rst_sys),
        .clear_req   (clear_req),
        .pt_wr_en    (pt_wr_en),
        .pt_wr_x     (pt_wr_x),
        .pt_wr_y     (pt_wr_y),
        .pt_wr_data  (pt_wr_data),
        .clear_busy  (clear_busy),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_din      (fb_din),
        .frame_done  (frame_done),
        .drop_cnt    (drop_cnt),
        .pts_written (pts_written)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_sweep();
        for (int i = 0; i < FB_DEPTH; i++) begin
            sb.push_back({16'(i), 1'b0});
        end
    endtask

    // Advance one cycle, then check any framebuffer write against the scoreboard
    task automatic step();
        @(posedge clk_sys);
        #1;
        sw++;
        if (frame_done) done_cnt++;
        if (fb_we) begin
            chk("wr_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_wr = sb.pop_front();
                chk("wr_addr_din", {15'd0, fb_addr, fb_din}, {15'd0, exp_wr});
            end
        end
    endtask

    task automatic run_to(input int j);
        while (sw < j) step();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_we"},    32'(fb_we),       32'd0);
        chk({tag, "_addr"},  32'(fb_addr),     32'd0);
        chk({tag, "_din"},   32'(fb_din),      32'd0);
        chk({tag, "_done"},  32'(frame_done),  32'd0);
        chk({tag, "_drop"},  32'(drop_cnt),    32'd0);
        chk({tag, "_pts"},   32'(pts_written), 32'd0);
        chk({tag, "_busy"},  32'(clear_busy),  32'd1);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        sw         = 0;
        done_cnt   = 0;
        rst_sys    = 1'b1;
        clear_req  = 1'b0;
        pt_wr_en   = 1'b0;
        pt_wr_x    = 8'h00;
        pt_wr_y    = 8'h00;
        pt_wr_data = 1'b0;

        // Reset values
        step(); step(); step();
        chk_reset("rst_init");

        // Automatic sweep after reset, aborted by reset at address 0x8000
        rst_sys = 1'b0;
        sw = 0;
        push_sweep();
        run_to(32'h8001);
        chk("mid_addr", 32'(fb_addr), 32'h8000);
        chk("mid_busy", 32'(clear_busy), 32'd1);
        rst_sys = 1'b1;
        sb.delete();
        step();
        chk_reset("rst_mid");
        step();

        // Restarted full sweep from address 0
        rst_sys = 1'b0;
        sw = 0;
        push_sweep();
        done0 = done_cnt;
        step();
        chk("restart_we", 32'(fb_we), 32'd1);
        chk("restart_addr", 32'(fb_addr), 32'd0);
        run_to(65536);
        chk("sw1_last_addr", 32'(fb_addr), 32'hFFFF);
        chk("sw1_last_busy", 32'(clear_busy), 32'd1);
        chk("sw1_last_done", 32'(frame_done), 32'd0);
        step();
        chk("sw1_end_busy", 32'(clear_busy), 32'd0);
        chk("sw1_end_done", 32'(frame_done), 32'd1);
        chk("sw1_end_we", 32'(fb_we), 32'd0);
        step();
        chk("sw1_done_pulse", 32'(frame_done), 32'd0);
        chk("sw1_done_count", 32'(done_cnt - done0), 32'd1);
        chk("sw1_sb_drained", 32'(sb.size()), 32'd0);

        // Idle point write, one-cycle latency
        pt_wr_en   = 1'b1;
        pt_wr_x    = 8'h12;
        pt_wr_y    = 8'h34;
        pt_wr_data = 1'b1;
        sb.push_back({16'h3412, 1'b1});
        step();
        pt_wr_en = 1'b0;
        chk("pt_we", 32'(fb_we), 32'd1);
        chk("pt_pts", 32'(pts_written), 32'd1);
        step();
        chk("idle_we", 32'(fb_we), 32'd0);
        chk("idle_addr_hold", 32'(fb_addr), 32'h3412);
        chk("idle_din_hold", 32'(fb_din), 32'd1);

        // Clear and point write together: clear wins
        clear_req  = 1'b1;
        pt_wr_en   = 1'b1;
        pt_wr_x    = 8'h05;
        pt_wr_y    = 8'h06;
        pt_wr_data = 1'b1;
        sw = 0;
        push_sweep();
        done0 = done_cnt;
        step();
        clear_req = 1'b0;
        pt_wr_en  = 1'b0;
        chk("coll_drop", 32'(drop_cnt), 32'd1);
        chk("coll_addr", 32'(fb_addr), 32'd0);
        chk("coll_pts", 32'(pts_written), 32'd0);
        chk("coll_busy", 32'(clear_busy), 32'd1);

        // Point writes at sweep cycles 1, 1000, 65535 and a second clear at 500
        pt_wr_en = 1'b1;
        step();
        pt_wr_en = 1'b0;
        run_to(500);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        run_to(1000);
        pt_wr_en = 1'b1;
        step();
        pt_wr_en = 1'b0;
        run_to(65535);
        pt_wr_en = 1'b1;
        step();
        pt_wr_en = 1'b0;
        chk("sw2_drop", 32'(drop_cnt), 32'd4);
        chk("sw2_last_addr", 32'(fb_addr), 32'hFFFF);
        chk("sw2_last_busy", 32'(clear_busy), 32'd1);
        chk("sw2_pts", 32'(pts_written), 32'd0);
        step();
        chk("sw2_end_busy", 32'(clear_busy), 32'd0);
        chk("sw2_end_done", 32'(frame_done), 32'd1);
        chk("sw2_end_we", 32'(fb_we), 32'd0);

        // Point write while frame_done is high is accepted
        pt_wr_en   = 1'b1;
        pt_wr_x    = 8'hAB;
        pt_wr_y    = 8'hCD;
        pt_wr_data = 1'b1;
        sb.push_back({16'hCDAB, 1'b1});
        step();
        pt_wr_en = 1'b0;
        chk("fd_pt_we", 32'(fb_we), 32'd1);
        chk("fd_pt_pts", 32'(pts_written), 32'd1);
        chk("fd_drop_hold", 32'(drop_cnt), 32'd4);
        step();
        step();
        chk("sw2_done_count", 32'(done_cnt - done0), 32'd1);
        chk("sw2_sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
